// File: rtl/uart_pkg.sv
// Shared UART types: transmitter FSM states, frame configuration and parity helper.
// Used by the TX engine and the APB register block.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_DIV_MAX_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_e;

  typedef struct packed {
    logic [UART_DIV_MAX_W-1:0] div;
    logic                      stop2;
    logic                      parity_en;
    logic                      parity_odd;
  } uart_frame_cfg_t;

  // Even parity makes the total count of ones even; odd parity is its complement.
  function automatic logic uart_parity_bit(input logic [UART_DATA_BITS-1:0] data,
                                           input logic                      odd);
    uart_parity_bit = odd ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// Write handshake between the register block (master) and the TX engine (slave).
interface uart_tx_engine_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] wdata;
  logic                      wvalid;
  logic                      wready;

  modport master (output wdata, output wvalid, input wready);
  modport slave  (input wdata, input wvalid, output wready);

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy count; shared by the UART TX and RX paths.
// Pushes while full and pops while empty are ignored.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == (AW+1)'(DEPTH));
  assign empty  = (r_count == {(AW+1){1'b0}});
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign rdata  = r_mem[r_rd_ptr];
  assign count  = r_count;

  // Storage array: no reset needed, an entry is only read after being written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally; count holds on simultaneous push and pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {(AW+1){1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: byte FIFO feeding a start/data/parity/stop serializer.
// Optional parity bit built only when UART_TX_PARITY_EN is defined.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int  DIV_WIDTH  = 16,
  parameter int  FIFO_DEPTH = 8,
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 pclk,
  input  logic                 presetn,
  input  logic                 tx_en,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 stop2,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  uart_tx_engine_if.slave      wr_if,
  output logic                 txd,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic [CNT_W-1:0]     fifo_cnt,
  output logic                 fifo_empty,
  output logic                 fifo_full
);

  uart_tx_state_e            r_state;
  uart_tx_state_e            w_state_nxt;
  logic [DIV_WIDTH-1:0]      r_baud_cnt;
  logic [DIV_WIDTH-1:0]      w_baud_nxt;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] w_shift_nxt;
  logic [2:0]                r_bit_idx;
  logic [2:0]                w_bit_idx_nxt;
  logic                      r_stop_idx;
  logic                      w_stop_idx_nxt;
  uart_frame_cfg_t           r_cfg;
  uart_frame_cfg_t           w_cfg_nxt;
  uart_frame_cfg_t           w_cfg_in;
  logic                      r_txd;
  logic                      w_txd_nxt;
  logic                      r_tx_busy;
  logic                      r_tx_done;
  logic                      w_done_nxt;

  logic                      w_pop;
  logic                      w_load;
  logic                      w_bit_end;
  logic                      w_start_ok;
  logic [DIV_WIDTH-1:0]      w_reload;
  logic [UART_DATA_BITS-1:0] w_fifo_rdata;
  logic [CNT_W-1:0]          w_fifo_cnt;
  logic                      w_fifo_full;
  logic                      w_fifo_empty;

`ifdef UART_TX_PARITY_EN
  logic [UART_DATA_BITS-1:0] r_byte;
  logic [UART_DATA_BITS-1:0] w_byte_nxt;
`else
  logic                      w_unused_parity;
  assign w_unused_parity = r_cfg.parity_en ^ r_cfg.parity_odd;
`endif

  uart_sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (pclk),
    .rst_n (presetn),
    .push  (wr_if.wvalid),
    .wdata (wr_if.wdata),
    .pop   (w_pop),
    .rdata (w_fifo_rdata),
    .count (w_fifo_cnt),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  assign wr_if.wready = !w_fifo_full;
  assign fifo_cnt     = w_fifo_cnt;
  assign fifo_full    = w_fifo_full;
  assign fifo_empty   = w_fifo_empty;
  assign txd          = r_txd;
  assign tx_busy      = r_tx_busy;
  assign tx_done      = r_tx_done;

  assign w_cfg_in.div        = UART_DIV_MAX_W'(baud_div);
  assign w_cfg_in.stop2      = stop2;
  assign w_cfg_in.parity_en  = parity_en;
  assign w_cfg_in.parity_odd = parity_odd;

  assign w_bit_end  = (r_baud_cnt == {DIV_WIDTH{1'b0}});
  assign w_start_ok = tx_en && !w_fifo_empty;
  assign w_reload   = r_cfg.div[DIV_WIDTH-1:0];

  // Next-state logic; a frame load (from IDLE or back-to-back from STOP) is shared.
  always_comb begin
    w_state_nxt    = r_state;
    w_baud_nxt     = r_baud_cnt;
    w_shift_nxt    = r_shift;
    w_bit_idx_nxt  = r_bit_idx;
    w_stop_idx_nxt = r_stop_idx;
    w_cfg_nxt      = r_cfg;
    w_txd_nxt      = r_txd;
    w_pop          = 1'b0;
    w_load         = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_byte_nxt     = r_byte;
`endif

    case (r_state)
      IDLE: begin
        if (w_start_ok) begin
          w_load = 1'b1;
        end else begin
          w_txd_nxt = 1'b1;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_nxt   = DATA;
          w_baud_nxt    = w_reload;
          w_txd_nxt     = r_shift[0];
          w_shift_nxt   = {1'b0, r_shift[UART_DATA_BITS-1:1]};
          w_bit_idx_nxt = 3'd0;
        end else begin
          w_baud_nxt = r_baud_cnt - DIV_WIDTH'(1);
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_baud_nxt = w_reload;
          if (r_bit_idx == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            if (r_cfg.parity_en) begin
              w_state_nxt = PARITY;
              w_txd_nxt   = uart_parity_bit(r_byte, r_cfg.parity_odd);
            end else begin
              w_state_nxt    = STOP;
              w_txd_nxt      = 1'b1;
              w_stop_idx_nxt = 1'b0;
            end
`else
            w_state_nxt    = STOP;
            w_txd_nxt      = 1'b1;
            w_stop_idx_nxt = 1'b0;
`endif
          end else begin
            w_txd_nxt     = r_shift[0];
            w_shift_nxt   = {1'b0, r_shift[UART_DATA_BITS-1:1]};
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end else begin
          w_baud_nxt = r_baud_cnt - DIV_WIDTH'(1);
        end
      end
      PARITY: begin
        if (w_bit_end) begin
          w_state_nxt    = STOP;
          w_baud_nxt     = w_reload;
          w_txd_nxt      = 1'b1;
          w_stop_idx_nxt = 1'b0;
        end else begin
          w_baud_nxt = r_baud_cnt - DIV_WIDTH'(1);
        end
      end
      STOP: begin
        if (!w_bit_end) begin
          w_baud_nxt = r_baud_cnt - DIV_WIDTH'(1);
        end else if (r_stop_idx != r_cfg.stop2) begin
          w_stop_idx_nxt = 1'b1;
          w_baud_nxt     = w_reload;
        end else if (w_start_ok) begin
          w_load = 1'b1;
        end else begin
          w_state_nxt = IDLE;
          w_txd_nxt   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_txd_nxt   = 1'b1;
      end
    endcase

    // Frame settings are captured here and held until the frame ends.
    if (w_load) begin
      w_pop          = 1'b1;
      w_state_nxt    = START;
      w_shift_nxt    = w_fifo_rdata;
      w_cfg_nxt      = w_cfg_in;
      w_baud_nxt     = baud_div;
      w_txd_nxt      = 1'b0;
      w_bit_idx_nxt  = 3'd0;
      w_stop_idx_nxt = 1'b0;
`ifdef UART_TX_PARITY_EN
      w_byte_nxt     = w_fifo_rdata;
`endif
    end else begin
      w_pop = 1'b0;
    end
  end

  // tx_done is registered, so it is predicted from the cycle about to begin.
  assign w_done_nxt = (w_state_nxt == STOP) &&
                      (w_baud_nxt == {DIV_WIDTH{1'b0}}) &&
                      (w_stop_idx_nxt == w_cfg_nxt.stop2);

  // State and output registers; reset abandons any frame and idles the line.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_state          <= IDLE;
      r_baud_cnt       <= {DIV_WIDTH{1'b0}};
      r_shift          <= {UART_DATA_BITS{1'b0}};
      r_bit_idx        <= 3'd0;
      r_stop_idx       <= 1'b0;
      r_cfg.div        <= {UART_DIV_MAX_W{1'b0}};
      r_cfg.stop2      <= 1'b0;
      r_cfg.parity_en  <= 1'b0;
      r_cfg.parity_odd <= 1'b0;
      r_txd            <= 1'b1;
      r_tx_busy        <= 1'b0;
      r_tx_done        <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_nxt;
      r_shift    <= w_shift_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_stop_idx <= w_stop_idx_nxt;
      r_cfg      <= w_cfg_nxt;
      r_txd      <= w_txd_nxt;
      r_tx_busy  <= (w_state_nxt != IDLE);
      r_tx_done  <= w_done_nxt;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Copy of the frame byte kept intact for the parity bit while the shifter drains.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_byte <= {UART_DATA_BITS{1'b0}};
    end else begin
      r_byte <= w_byte_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_engine.sv
// Randomized scoreboard bench for uart_tx_engine: accepted bytes are queued, and a
// line monitor decodes each frame against a bit-level model of the frame format.
`timescale 1ns/1ps
module tb_uart_tx_engine;
  import uart_pkg::*;

  localparam int DIV_WIDTH  = 16;
  localparam int FIFO_DEPTH = 8;
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

  logic                 pclk = 1'b0;
  logic                 presetn = 1'b0;
  logic                 tx_en = 1'b0;
  logic [DIV_WIDTH-1:0] baud_div = '0;
  logic                 stop2 = 1'b0;
  logic                 parity_en = 1'b0;
  logic                 parity_odd = 1'b0;
  logic                 txd;
  logic                 tx_busy;
  logic                 tx_done;
  logic [CNT_W-1:0]     fifo_cnt;
  logic                 fifo_empty;
  logic                 fifo_full;

  uart_tx_engine_if wr_if ();

  uart_tx_engine #(.DIV_WIDTH(DIV_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .pclk       (pclk),
    .presetn    (presetn),
    .tx_en      (tx_en),
    .baud_div   (baud_div),
    .stop2      (stop2),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .wr_if      (wr_if.slave),
    .txd        (txd),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .fifo_cnt   (fifo_cnt),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full)
  );

  always #5 pclk = ~pclk;

  int          total = 0;
  int          bad = 0;
  logic [7:0]  exp_q [$];
  int          snap_div = 0;
  logic        snap_en = 1'b0;
  logic        snap_stop2 = 1'b0;
  logic        snap_pen = 1'b0;
  logic        snap_podd = 1'b0;
  logic        mon_in_frame = 1'b0;
  logic        must_start = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Settings seen at this negedge are what the following clock edge samples.
  task automatic take_snap();
    snap_div   = int'(baud_div);
    snap_en    = tx_en;
    snap_stop2 = stop2;
    snap_pen   = parity_en;
    snap_podd  = parity_odd;
  endtask

  // Frame bit k: 0 start, 1..8 data LSB first, optional parity, then stop bits.
  function automatic logic exp_bit(input logic [7:0] b, input int k, input logic pen,
                                   input logic podd);
    int ones;
    ones = $countones(b);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (pen && k == 9) return logic'(ones % 2) ^ podd;
    return 1'b1;
  endfunction

  // Line monitor: checks idle line, frame bits, busy, done pulse and no-gap rule.
  initial begin : monitor
    logic [7:0] b;
    int         d;
    int         len;
    int         nbits;
    logic       pen;
    logic       podd;
    forever begin
      @(negedge pclk);
      if (!presetn) begin
        exp_q.delete();
        must_start   = 1'b0;
        mon_in_frame = 1'b0;
        take_snap();
      end else begin
        if (must_start) chk("start_on_time", 32'(txd), 32'd0);
        if (txd === 1'b0) begin
          chk("start_enabled", 32'(snap_en), 32'd1);
          chk("start_has_data", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            mon_in_frame = 1'b1;
            d = snap_div;
`ifdef UART_TX_PARITY_EN
            pen = snap_pen;
`else
            pen = 1'b0;
`endif
            podd  = snap_podd;
            nbits = 9 + (pen ? 1 : 0) + (snap_stop2 ? 2 : 1);
            len   = nbits * (d + 1);
            for (int c = 0; c < len; c++) begin
              if (c > 0) @(negedge pclk);
              if (!presetn) begin
                exp_q.delete();
                must_start = 1'b0;
                break;
              end
              chk("txd_bit", 32'(txd), 32'(exp_bit(b, c / (d + 1), pen, podd)));
              chk("busy_in_frame", 32'(tx_busy), 32'd1);
              chk("done_pulse", 32'(tx_done), 32'(c == len - 1));
              must_start = (c == len - 1) && tx_en && (exp_q.size() > 0);
              take_snap();
            end
            mon_in_frame = 1'b0;
          end else begin
            take_snap();
          end
        end else begin
          chk("idle_txd", 32'(txd), 32'd1);
          chk("idle_busy", 32'(tx_busy), 32'd0);
          chk("idle_done", 32'(tx_done), 32'd0);
          must_start = tx_en && (exp_q.size() > 0);
          take_snap();
        end
      end
    end
  end

  // Holds wvalid until the byte is taken; the accepting edge queues the expectation.
  task automatic push_byte(input logic [7:0] b);
    logic acc;
    acc = 1'b0;
    wr_if.wdata  = b;
    wr_if.wvalid = 1'b1;
    for (int i = 0; i < 400 && !acc; i++) begin
      @(negedge pclk);
      acc = wr_if.wready;
      @(posedge pclk);
      if (acc) exp_q.push_back(b);
    end
    chk("push_accepted", 32'(acc), 32'd1);
    #1;
    wr_if.wvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while ((exp_q.size() != 0 || mon_in_frame) && i < 3000) begin
      @(posedge pclk);
      #2;
      i++;
    end
    chk("drain_timeout", 32'(i < 3000), 32'd1);
    @(negedge pclk);
    @(negedge pclk);
    @(posedge pclk);
    #1;
  endtask

  initial begin : stim
    int         cyc;
    int         n;
    logic [7:0] b9;
    wr_if.wdata  = 8'h00;
    wr_if.wvalid = 1'b0;
    repeat (3) @(posedge pclk);
    #1 presetn = 1'b1;
    @(negedge pclk);
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_done", 32'(tx_done), 32'd0);
    chk("rst_cnt", 32'(fifo_cnt), 32'd0);
    chk("rst_empty", 32'(fifo_empty), 32'd1);
    chk("rst_full", 32'(fifo_full), 32'd0);
    chk("rst_wready", 32'(wr_if.wready), 32'd1);
    @(posedge pclk);
    #1;

    // 0x55 at divisor 3: start one edge after acceptance, done in cycle 40.
    baud_div = 16'd3; stop2 = 1'b0; parity_en = 1'b0; tx_en = 1'b1;
    push_byte(8'h55);
    @(negedge pclk);
    chk("lat_pre", 32'(txd), 32'd1);
    @(negedge pclk);
    chk("lat_start", 32'(txd), 32'd0);
    cyc = 1;
    while (!tx_done && cyc < 200) begin
      @(negedge pclk);
      cyc++;
    end
    chk("frame_cycles", 32'(cyc), 32'd40);
    @(negedge pclk);
    chk("busy_drop", 32'(tx_busy), 32'd0);
    wait_idle();

    // Fill the FIFO with the transmitter disabled; the ninth write must stall.
    tx_en = 1'b0;
    baud_div = 16'($urandom_range(0, 1));
    stop2 = 1'($urandom_range(0, 1));
    for (int i = 0; i < FIFO_DEPTH; i++) push_byte(8'($urandom));
    @(negedge pclk);
    chk("fill_cnt", 32'(fifo_cnt), 32'(FIFO_DEPTH));
    chk("fill_full", 32'(fifo_full), 32'd1);
    chk("fill_wready", 32'(wr_if.wready), 32'd0);
    chk("fill_empty", 32'(fifo_empty), 32'd0);
    @(posedge pclk);
    #1;
    b9 = 8'($urandom);
    wr_if.wdata  = b9;
    wr_if.wvalid = 1'b1;
    repeat (3) begin
      @(negedge pclk);
      chk("held_not_ready", 32'(wr_if.wready), 32'd0);
      chk("held_cnt", 32'(fifo_cnt), 32'(FIFO_DEPTH));
    end
    @(posedge pclk);
    #1 tx_en = 1'b1;
    push_byte(b9);
    wait_idle();

    // Two back-to-back frames at divisor 0 with even parity and two stop bits.
    baud_div = 16'd0; parity_en = 1'b1; parity_odd = 1'b0; stop2 = 1'b1; tx_en = 1'b1;
    push_byte(8'h07);
    push_byte(8'h03);
    wait_idle();

    // Parity requested on 0xA5 with one stop bit.
    stop2 = 1'b0;
    push_byte(8'hA5);
    wait_idle();

    // Randomized batches, sometimes preloaded, with settings changed mid-frame.
    for (int t = 0; t < 8; t++) begin
      baud_div   = 16'($urandom_range(0, 3));
      stop2      = 1'($urandom_range(0, 1));
      parity_en  = 1'($urandom_range(0, 1));
      parity_odd = 1'($urandom_range(0, 1));
      tx_en      = 1'(t % 2);
      n = int'($urandom_range(1, 5));
      for (int k = 0; k < n; k++) begin
        push_byte(8'($urandom));
        if ($urandom_range(0, 2) == 0) begin
          baud_div   = 16'($urandom_range(0, 3));
          stop2      = 1'($urandom_range(0, 1));
          parity_odd = 1'($urandom_range(0, 1));
        end
      end
      tx_en = 1'b1;
      repeat (int'($urandom_range(1, 20))) @(posedge pclk);
      #1;
      baud_div  = 16'($urandom_range(0, 3));
      parity_en = 1'($urandom_range(0, 1));
      wait_idle();
    end

    // Reset during data bit 4 of 0xFF with three bytes still queued.
    baud_div = 16'd3; stop2 = 1'b0; parity_en = 1'b0; tx_en = 1'b0;
    push_byte(8'hFF);
    for (int i = 0; i < 3; i++) push_byte(8'($urandom));
    tx_en = 1'b1;
    cyc = 0;
    do begin
      @(negedge pclk);
      cyc++;
    end while (txd !== 1'b0 && cyc < 10);
    chk("rst_frame_started", 32'(txd), 32'd0);
    repeat (21) @(negedge pclk);
    @(posedge pclk);
    #1 presetn = 1'b0;
    @(posedge pclk);
    #1 presetn = 1'b1;
    @(negedge pclk);
    chk("midrst_txd", 32'(txd), 32'd1);
    chk("midrst_cnt", 32'(fifo_cnt), 32'd0);
    chk("midrst_busy", 32'(tx_busy), 32'd0);
    chk("midrst_empty", 32'(fifo_empty), 32'd1);
    repeat (60) @(negedge pclk);
    chk("midrst_quiet_cnt", 32'(fifo_cnt), 32'd0);
    @(posedge pclk);
    #1;

    // tx_en dropped during START of 0x3C: that frame completes, the rest wait.
    baud_div = 16'($urandom_range(0, 2)); stop2 = 1'($urandom_range(0, 1)); tx_en = 1'b0;
    push_byte(8'h3C);
    push_byte(8'($urandom));
    push_byte(8'($urandom));
    tx_en = 1'b1;
    @(posedge pclk);
    #1 tx_en = 1'b0;
    @(negedge pclk);
    chk("drop_in_start", 32'(txd), 32'd0);
    repeat (60) @(negedge pclk);
    chk("drop_cnt", 32'(fifo_cnt), 32'd2);
    chk("drop_busy", 32'(tx_busy), 32'd0);
    chk("drop_txd", 32'(txd), 32'd1);
    @(posedge pclk);
    #1 tx_en = 1'b1;
    wait_idle();

    repeat (5) @(posedge pclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
# uart_tx_engine

Transmit-side serializer directly downstream of the APB UART register block. It accepts bytes written to the TX data register through a valid/ready handshake and buffers them in a small FIFO. It then shifts them out on `txd` as asynchronous serial frames (start, 8 data LSB-first, optional parity, 1 or 2 stop) at a programmable baud divisor. Status outputs feed the register block's status and interrupt bits.

## Interface
- `DIV_WIDTH`, 16: width of baud divisor.
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, ≥2.
- `pclk`  in  1  clock; all logic on rising edge.
- `presetn`  in  1  reset, synchronous, active-low.
- `tx_en`  in  1  transmitter enable.
- `baud_div`  in  DIV_WIDTH  bit period = baud_div+1 pclk cycles.
- `stop2`  in  1  1 = two stop bits.
- `parity_en`  in  1  insert parity bit.
- `parity_odd`  in  1  1 = odd, 0 = even.
- `wdata`  in  8  byte to transmit.
- `wvalid`  in  1  wdata valid.
- `wready`  out  1  FIFO can accept (= !fifo_full).
- `txd`  out  1  serial line, idle high.
- `tx_busy`  out  1  frame in progress (state ≠ IDLE).
- `tx_done`  out  1  one-cycle pulse in last cycle of final stop bit.
- `fifo_cnt`  out  $clog2(FIFO_DEPTH)+1  entries held.
- `fifo_empty`, `fifo_full`  out  1 each.

## Operation
- Push on `wvalid && wready`. No push when full; the write is not dropped, the producer holds.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE → START when `tx_en && !fifo_empty`. On that edge: pop the FIFO, load the shifter, latch `baud_div`/`stop2`/parity settings for the whole frame, set `txd`=0.
- START → DATA after one bit period. DATA drives `shifter[0]`, shifts right, and leaves after 8 bits. It goes to PARITY if the latched parity_en is set, else to STOP.
- PARITY drives `^byte` when even and `~^byte` when odd, for one bit period, then goes to STOP.
- STOP drives 1 for 1 or 2 bit periods. In its last cycle: `tx_done`=1. If `tx_en && !fifo_empty`, pop and go straight to START with no idle gap; else go to IDLE.
- Bit counter: a down-counter of DIV_WIDTH bits reloads `baud_div` at every bit boundary; the bit ends when it reads 0. `baud_div`=0 gives 1-cycle bits.
- Deasserting `tx_en` mid-frame has no effect until the frame completes; bytes stay in the FIFO.
- Changes to `baud_div`, `stop2` or parity mid-frame take effect at the next frame only.
- Simultaneous push and pop: `fifo_cnt` is unchanged, and push into an empty FIFO plus pop in the same cycle cannot occur (pop sees pre-edge empty).
- FIFO pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally.

## Timing
- All outputs are registered except `wready`, `fifo_full` and `fifo_empty`, which are decoded from registered `fifo_cnt`.
- Reset values: `txd`=1, `tx_busy`=0, `tx_done`=0, `fifo_cnt`=0, `fifo_empty`=1, `fifo_full`=0, `wready`=1, state IDLE.
- Reset asserted mid-frame: next edge `txd`=1, FIFO flushed, partial frame abandoned.
- Latency: a byte accepted at edge N into an empty FIFO with IDLE and tx_en=1 gives `txd`=0 from edge N+1.
- Frame length: (1+8+P+S)×(baud_div+1) cycles, where P∈{0,1} and S∈{1,2}.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state and parity logic are built, and `parity_en`/`parity_odd` are honoured.
- Undefined: ports remain but are ignored, PARITY is never entered, and frames are always 9+S bits.

## Structure
- Package `uart_pkg`:
  - `uart_tx_state_e` enum (IDLE, START, DATA, PARITY, STOP).
  - `UART_DATA_BITS`=8.
  - `uart_frame_cfg_t` struct (div, stop2, parity_en, parity_odd), shared with the register block.
- Sub-module `uart_sync_fifo` (parameters WIDTH, DEPTH): push/pop/count/full/empty. It is reused later by the RX path.

## Test plan
- baud_div=3, no parity, stop2=0, write 0x55 → `txd` 0,1,0,1,0,1,0,1,0,1, each held 4 cycles; 40 cycles total; `tx_done` pulse in cycle 40; `tx_busy` then drops.
- Write 9 bytes back-to-back with tx_en=0, FIFO_DEPTH=8 → `wready` low after 8; `fifo_cnt`=8; ninth accepted only after tx_en=1 and the first pop.
- baud_div=0, parity_en=1, parity_odd=0, stop2=1, bytes 0x07 then 0x03 → frame 1 parity=1, frame 2 parity=0; each frame 12 cycles; no idle gap between frames.
- Macro undefined, parity_en=1, byte 0xA5 → 10-bit frame, no parity bit.
- Reset pulse in DATA bit 4 of 0xFF with 3 bytes queued → next edge `txd`=1, `fifo_cnt`=0, `tx_busy`=0; no frame follows.
- tx_en dropped during START of byte 0x3C with 2 queued → 0x3C completes; `txd` stays 1; `fifo_cnt`=2.
